// File: rtl/serial_crc_checker_if.sv
// Bit-stream and result bundle for the serial CRC-16 checker.
//   master : bit source side (drives start/bit_valid/bit_in, observes results)
//   slave  : checker side (consumes bits, drives busy/done/crc_ok/crc_err/crc_calc/rx_crc)
interface serial_crc_checker_if;
  logic        start;
  logic        bit_valid;
  logic        bit_in;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] crc_calc;
  logic [15:0] rx_crc;

  modport master (
    output start, bit_valid, bit_in,
    input  busy, done, crc_ok, crc_err, crc_calc, rx_crc
  );

  modport slave (
    input  start, bit_valid, bit_in,
    output busy, done, crc_ok, crc_err, crc_calc, rx_crc
  );
endinterface

// File: rtl/serial_crc_checker.sv
// Serial CRC-16 checker: takes PAYLOAD_LEN payload bits followed by 16 CRC bits
// (crc[15] first), recomputes the CRC over the payload and compares it with the
// received CRC. Reports the result with a one-cycle done pulse; crc_ok/crc_err hold
// until the next start.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport (start, bit_valid, bit_in in; busy, done, crc_ok,
//             crc_err, crc_calc, rx_crc out)
module serial_crc_checker #(
  parameter int unsigned PAYLOAD_LEN = 32,
  parameter logic [15:0] CRC_INIT    = 16'h000F
) (
  input logic                 clk,
  input logic                 reset_n,
  serial_crc_checker_if.slave bus
);

  localparam int unsigned CntW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CntW-1:0] LastPayload = CntW'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {StIdle, StPayload, StCrcRx, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     rx_q, rx_d;
  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic [4:0]      ccnt_q, ccnt_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            arm;
  logic [15:0]     rx_shift;

  // Feedback lands in bits 0/4/8/12; crc[3], crc[7], crc[11] are dropped.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:12], fb, c[10:8], fb, c[6:4], fb, c[2:0], fb};
  endfunction

  assign rx_shift = {rx_q[14:0], bus.bit_in};

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    pcnt_d  = pcnt_q;
    ccnt_d  = ccnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    arm     = 1'b0;

    unique case (state_q)
      StIdle: arm = bus.start;
      StPayload: begin
        if (bus.start) begin
          arm = 1'b1;
        end else if (bus.bit_valid) begin
          crc_d = crc_step(crc_q, bus.bit_in);
          if (pcnt_q == LastPayload) begin
            pcnt_d  = '0;
            state_d = StCrcRx;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      StCrcRx: begin
        if (bus.start) begin
          arm = 1'b1;
        end else if (bus.bit_valid) begin
          rx_d = rx_shift;
          if (ccnt_q == 5'd15) begin
            ccnt_d  = '0;
            state_d = StDone;
            // Result is latched with the last bit so it is visible alongside done.
            ok_d    = (rx_shift == crc_q);
            err_d   = (rx_shift != crc_q);
          end else begin
            ccnt_d = ccnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        arm     = bus.start;
      end
      default: state_d = StIdle;
    endcase

    // Start from any state re-arms; an in-flight frame is abandoned without done.
    if (arm) begin
      state_d = StPayload;
      crc_d   = CRC_INIT;
      rx_d    = '0;
      pcnt_d  = '0;
      ccnt_d  = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      crc_q   <= CRC_INIT;
      rx_q    <= '0;
      pcnt_q  <= '0;
      ccnt_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      pcnt_q  <= pcnt_d;
      ccnt_q  <= ccnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy     = (state_q == StPayload) || (state_q == StCrcRx);
  assign bus.done     = (state_q == StDone);
  assign bus.crc_ok   = ok_q;
  assign bus.crc_err  = err_q;
  assign bus.crc_calc = crc_q;
  assign bus.rx_crc   = rx_q;

endmodule

// File: tb/tb_serial_crc_checker.sv
// Testbench for serial_crc_checker: table-driven frames on a PAYLOAD_LEN=4 instance,
// hand-written corner sequences, and randomized frames on both a 4-bit and a 32-bit
// instance checked against a mask-based CRC model.
module tb_serial_crc_checker;

  logic clk = 1'b0;
  logic reset_n;
  logic start = 1'b0;
  logic bv = 1'b0;
  logic bi = 1'b0;
  logic sel = 1'b0;  // 0: observe 4-bit instance, 1: observe 32-bit instance

  always #5 clk = ~clk;

  serial_crc_checker_if if4 ();
  serial_crc_checker_if if32 ();

  assign if4.start      = start;
  assign if4.bit_valid  = bv;
  assign if4.bit_in     = bi;
  assign if32.start     = start;
  assign if32.bit_valid = bv;
  assign if32.bit_in    = bi;

  serial_crc_checker #(.PAYLOAD_LEN(4), .CRC_INIT(16'h000F)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4)
  );
  serial_crc_checker #(.PAYLOAD_LEN(32), .CRC_INIT(16'h000F)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(if32)
  );

  logic        o_busy, o_done, o_ok, o_err;
  logic [15:0] o_calc, o_rx;
  assign o_busy = sel ? if32.busy : if4.busy;
  assign o_done = sel ? if32.done : if4.done;
  assign o_ok   = sel ? if32.crc_ok : if4.crc_ok;
  assign o_err  = sel ? if32.crc_err : if4.crc_err;
  assign o_calc = sel ? if32.crc_calc : if4.crc_calc;
  assign o_rx   = sel ? if32.rx_crc : if4.rx_crc;

  int checks = 0;
  int failures = 0;
  int done_cnt4 = 0;

  always @(negedge clk) if (if4.done === 1'b1) done_cnt4++;

  typedef struct {
    logic [3:0]  pl;     // pl[3] is sent first
    logic [15:0] rx;
    logic [15:0] calc;
    logic        ok;
    int unsigned gmax;
  } vec_t;

  vec_t tbl[5];

  // Behavioural CRC: shift left, clear the four tap positions, then fill them with fb.
  function automatic logic [15:0] model_crc(input logic [31:0] pl, input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'h000F;
    for (int i = len - 1; i >= 0; i--) begin
      fb = pl[i] ^ c[15];
      c  = ((c << 1) & 16'hEEEE) | (fb ? 16'h1111 : 16'h0000);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic hold_bit);
    start = 1'b1;
    bv    = hold_bit;
    bi    = hold_bit;
    @(posedge clk);
    #1;
    start = 1'b0;
    bv    = 1'b0;
    bi    = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int unsigned gmax);
    repeat ($urandom_range(gmax, 0)) @(posedge clk);
    #0;
    bv = 1'b1;
    bi = b;
    @(posedge clk);
    #1;
    bv = 1'b0;
    bi = 1'b0;
  endtask

  task automatic send_body(input logic [31:0] pl, input int len, input logic [15:0] crc,
                           input int unsigned gmax);
    for (int i = len - 1; i >= 0; i--) send_bit(pl[i], gmax);
    for (int i = 15; i >= 0; i--) send_bit(crc[i], gmax);
  endtask

  // Called in the cycle right after the last CRC bit edge.
  task automatic check_result(input string tag, input logic [15:0] exp_calc,
                              input logic [15:0] crc, input logic exp_ok);
    chk({tag, ".done"}, o_done, 1'b1);
    chk({tag, ".busy"}, o_busy, 1'b0);
    chk({tag, ".ok"}, o_ok, exp_ok);
    chk({tag, ".err"}, o_err, !exp_ok);
    chk({tag, ".calc"}, o_calc, exp_calc);
    chk({tag, ".rx"}, o_rx, crc);
    @(posedge clk);
    #1;
    chk({tag, ".done_low"}, o_done, 1'b0);
    chk({tag, ".ok_held"}, o_ok, exp_ok);
  endtask

  initial begin
    logic [31:0] pl;
    logic [15:0] crc;
    logic [15:0] c;
    logic        exp_ok;
    int          cnt;
    int          k;

    tbl[0] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 0};
    tbl[1] = '{4'b1000, 16'h8888, 16'h8888, 1'b1, 0};
    tbl[2] = '{4'b1000, 16'h8889, 16'h8888, 1'b0, 0};
    tbl[3] = '{4'b1000, 16'h8888, 16'h8888, 1'b1, 5};
    tbl[4] = '{4'b0000, 16'h0001, 16'h0000, 1'b0, 3};

    // Reset values, sampled before any clock edge.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst.busy", o_busy, 1'b0);
    chk("rst.done", o_done, 1'b0);
    chk("rst.ok", o_ok, 1'b0);
    chk("rst.err", o_err, 1'b0);
    chk("rst.calc", o_calc, 16'h000F);
    chk("rst.rx", o_rx, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames.
    for (int t = 0; t < 5; t++) begin
      cnt = done_cnt4;
      do_start(1'b0);
      chk($sformatf("tbl%0d.busy", t), o_busy, 1'b1);
      send_body({28'd0, tbl[t].pl}, 4, tbl[t].rx, tbl[t].gmax);
      check_result($sformatf("tbl%0d", t), tbl[t].calc, tbl[t].rx, tbl[t].ok);
      chk($sformatf("tbl%0d.pulses", t), done_cnt4 - cnt, 1);
    end

    // Running CRC after each payload bit of 1,0,0,0, frozen during CRC reception.
    do_start(1'b0);
    send_bit(1'b1, 0); chk("seq.c1", o_calc, 16'h111F);
    send_bit(1'b0, 0); chk("seq.c2", o_calc, 16'h222E);
    send_bit(1'b0, 0); chk("seq.c3", o_calc, 16'h444C);
    send_bit(1'b0, 0); chk("seq.c4", o_calc, 16'h8888);
    for (int i = 15; i >= 8; i--) send_bit(1'b1, 1);
    chk("seq.frozen", o_calc, 16'h8888);
    chk("seq.rx_half", o_rx, 16'h00FF);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, 1);
    check_result("seq", 16'h8888, 16'hFF00, 1'b0);

    // bit_valid in IDLE is ignored.
    cnt = done_cnt4;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    chk("idle.busy", o_busy, 1'b0);
    chk("idle.calc", o_calc, 16'h8888);
    chk("idle.pulses", done_cnt4 - cnt, 0);

    // A valid bit on the start cycle is not consumed.
    do_start(1'b1);
    send_body(32'd0, 4, 16'h0000, 0);
    check_result("startbit", 16'h0000, 16'h0000, 1'b1);

    // Abort after two payload bits, then a full valid frame.
    cnt = done_cnt4;
    do_start(1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    do_start(1'b0);
    chk("abort.busy", o_busy, 1'b1);
    chk("abort.ok", o_ok, 1'b0);
    chk("abort.err", o_err, 1'b0);
    chk("abort.calc", o_calc, 16'h000F);
    send_body({28'd0, 4'b1000}, 4, 16'h8888, 2);
    check_result("abort", 16'h8888, 16'h8888, 1'b1);
    chk("abort.pulses", done_cnt4 - cnt, 1);

    // Start during the done cycle: result still shows, next cycle is re-armed.
    do_start(1'b0);
    send_body({28'd0, 4'b1000}, 4, 16'h8888, 0);
    chk("sdone.done", o_done, 1'b1);
    chk("sdone.ok", o_ok, 1'b1);
    do_start(1'b0);
    chk("sdone.busy", o_busy, 1'b1);
    chk("sdone.done_low", o_done, 1'b0);
    chk("sdone.ok_clr", o_ok, 1'b0);
    chk("sdone.calc", o_calc, 16'h000F);
    send_body(32'd0, 4, 16'h0000, 0);
    check_result("sdone2", 16'h0000, 16'h0000, 1'b1);

    // Asynchronous reset while receiving CRC bits.
    cnt = done_cnt4;
    do_start(1'b0);
    send_body({28'd0, 4'b1000}, 4, 16'h0000, 0);
    // The frame above completed; rerun a partial one for the mid-CRC reset.
    do_start(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(1'b1, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    chk("arst.busy_before", o_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.busy", o_busy, 1'b0);
    chk("arst.done", o_done, 1'b0);
    chk("arst.ok", o_ok, 1'b0);
    chk("arst.err", o_err, 1'b0);
    chk("arst.calc", o_calc, 16'h000F);
    chk("arst.rx", o_rx, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.pulses", done_cnt4 - cnt, 1);
    do_start(1'b0);
    send_body({28'd0, 4'b1000}, 4, 16'h8888, 1);
    check_result("arst.after", 16'h8888, 16'h8888, 1'b1);

    // Random 4-bit frames, good or corrupted CRC, random gaps.
    for (int n = 0; n < 20; n++) begin
      pl  = {28'd0, 4'($urandom)};
      c   = model_crc(pl, 4);
      crc = ($urandom_range(1, 0) == 1) ? c : c ^ 16'(($urandom_range(15, 0) + 1) << 1);
      exp_ok = (crc == c);
      do_start(1'b0);
      send_body(pl, 4, crc, 2);
      check_result($sformatf("rnd4_%0d", n), c, crc, exp_ok);
    end

    // 32-bit instance: generator-style frames, odd ones with a single flipped bit.
    sel = 1'b1;
    for (int n = 0; n < 10; n++) begin
      pl  = $urandom;
      crc = model_crc(pl, 32);
      if (n % 2 == 1) begin
        k = int'($urandom_range(47, 0));
        if (k < 32) pl[k] = ~pl[k];
        else crc[k-32] = ~crc[k-32];
      end
      c      = model_crc(pl, 32);
      exp_ok = (c == crc);
      do_start(1'b0);
      send_body(pl, 32, crc, 1);
      check_result($sformatf("rnd32_%0d", n), c, crc, exp_ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
